// File: rtl/ptmch_spi_cmd_tx.sv
`timescale 1ns/1ps
// SPI mode-0 master: sends an opcode byte plus 0-3 address bytes, MSB first, framed by CS.
// Latency: CS falls the cycle after CMD_START; DONE pulses P_CS_IDLE cycles after CS rises.
// Backpressure: CMD_START is only sampled in IDLE (including the DONE cycle); otherwise ignored.
module ptmch_spi_cmd_tx #(
    parameter int P_CLK_DIV  = 5,
    parameter int P_CS_SETUP = 4,
    parameter int P_CS_HOLD  = 4,
    parameter int P_CS_IDLE  = 8
) (
    input  logic        CLK200M,
    input  logic        RESET_N,
    input  logic        CMD_START,
    input  logic [7:0]  CMD_OPCODE,
    input  logic [23:0] CMD_ADDR,
    input  logic [1:0]  CMD_ADDR_LEN,
    output logic        CMD_BUSY,
    output logic        CMD_DONE,
    output logic        SPI_CS,
    output logic        SPI_CLK,
    output logic        SPI_MOSI
);

    localparam int DLY_MAX0 = (P_CS_SETUP > P_CS_HOLD) ? P_CS_SETUP : P_CS_HOLD;
    localparam int DLY_MAX  = (DLY_MAX0 > P_CS_IDLE) ? DLY_MAX0 : P_CS_IDLE;
    localparam int DLY_W    = $clog2(DLY_MAX + 1);
    localparam int PH_W     = $clog2(P_CLK_DIV + 1);

    localparam logic [DLY_W-1:0] SETUP_LAST = DLY_W'(P_CS_SETUP - 1);
    localparam logic [DLY_W-1:0] HOLD_LAST  = DLY_W'(P_CS_HOLD - 1);
    localparam logic [DLY_W-1:0] IDLE_LAST  = DLY_W'(P_CS_IDLE - 1);
    localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(P_CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [5:0]        bit_q, bit_d;
    logic [5:0]        last_q, last_d;
    logic [31:0]       sh_q, sh_d;
    logic              cs_q, cs_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // State and output registers; reset forces the bus idle immediately.
    always_ff @(posedge CLK200M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            dly_q   <= '0;
            ph_q    <= '0;
            bit_q   <= '0;
            last_q  <= '0;
            sh_q    <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            last_q  <= last_d;
            sh_q    <= sh_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: frame sequencing, SCK phase timing and MSB-first shifting.
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        last_d  = last_q;
        sh_d    = sh_q;
        cs_d    = cs_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (CMD_START) begin
                    // Left-align the used bytes so bit 31 is always the next bit out.
                    case (CMD_ADDR_LEN)
                        2'd0:    sh_d = {CMD_OPCODE, 24'h0};
                        2'd1:    sh_d = {CMD_OPCODE, CMD_ADDR[7:0], 16'h0};
                        2'd2:    sh_d = {CMD_OPCODE, CMD_ADDR[15:0], 8'h0};
                        default: sh_d = {CMD_OPCODE, CMD_ADDR};
                    endcase
                    last_d  = {1'b0, CMD_ADDR_LEN, 3'b111};
                    bit_d   = '0;
                    dly_d   = '0;
                    ph_d    = '0;
                    cs_d    = 1'b0;
                    sck_d   = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = CMD_OPCODE[7];
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (dly_q == SETUP_LAST) begin
                    dly_d   = '0;
                    ph_d    = '0;
                    state_d = ST_SHIFT;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            ST_SHIFT: begin
                if (ph_q == PH_LAST) begin
                    ph_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        // Falling edge: MOSI only ever moves here.
                        sck_d = 1'b0;
                        if (bit_q == last_q) begin
                            dly_d   = '0;
                            state_d = ST_HOLD;
                        end else begin
                            bit_d  = bit_q + 6'd1;
                            sh_d   = {sh_q[30:0], 1'b0};
                            mosi_d = sh_q[30];
                        end
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_HOLD: begin
                if (dly_q == HOLD_LAST) begin
                    dly_d   = '0;
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = ST_GAP;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            ST_GAP: begin
                if (dly_q == IDLE_LAST) begin
                    dly_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign CMD_BUSY = busy_q;
    assign CMD_DONE = done_q;
    assign SPI_CS   = cs_q;
    assign SPI_CLK  = sck_q;
    assign SPI_MOSI = mosi_q;

endmodule

// File: tb/tb_ptmch_spi_cmd_tx.sv
`timescale 1ns/1ps
// Bench for ptmch_spi_cmd_tx: directed frames on a default and a fast-SCK instance.
// Expected frames are queued when a command is issued; a monitor decodes the SPI bus.
// Each decoded frame is compared against the head of the queue.
module tb_ptmch_spi_cmd_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [7:0]  opcode = '0;
    logic [23:0] addr = '0;
    logic [1:0]  alen = '0;
    logic        sel = 1'b0;

    logic busy0, done0, cs0, sck0, mosi0;
    logic busy1, done1, cs1, sck1, mosi1;
    logic busy_m, done_m, cs_m, sck_m, mosi_m;

    always #2.5 clk = ~clk;

    ptmch_spi_cmd_tx u_dut (
        .CLK200M(clk), .RESET_N(rst_n), .CMD_START(start0), .CMD_OPCODE(opcode),
        .CMD_ADDR(addr), .CMD_ADDR_LEN(alen), .CMD_BUSY(busy0), .CMD_DONE(done0),
        .SPI_CS(cs0), .SPI_CLK(sck0), .SPI_MOSI(mosi0)
    );

    ptmch_spi_cmd_tx #(.P_CLK_DIV(1)) u_dut_fast (
        .CLK200M(clk), .RESET_N(rst_n), .CMD_START(start1), .CMD_OPCODE(opcode),
        .CMD_ADDR(addr), .CMD_ADDR_LEN(alen), .CMD_BUSY(busy1), .CMD_DONE(done1),
        .SPI_CS(cs1), .SPI_CLK(sck1), .SPI_MOSI(mosi1)
    );

    assign busy_m = sel ? busy1 : busy0;
    assign done_m = sel ? done1 : done0;
    assign cs_m   = sel ? cs1   : cs0;
    assign sck_m  = sel ? sck1  : sck0;
    assign mosi_m = sel ? mosi1 : mosi0;

    typedef struct {
        logic [31:0] word;
        int          nbits;
        int          cslow;
        int          gap;
        int          period;
        bit          abort;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    bit          in_frame = 0;
    bit          wait_done = 0;
    exp_t        cur;
    int          low_cnt, high_cnt, rises, gap_cnt, cyc, last_rise;
    int          per_err, mosi_err, busy_err, idle_sck_err;
    logic [31:0] word;
    logic        sck_p, mosi_p;

    initial begin
        cur = '{word: 32'h0, nbits: 0, cslow: 0, gap: 0, period: 0, abort: 1'b0};
        low_cnt = 0; high_cnt = 0; rises = 0; gap_cnt = 0; cyc = 0; last_rise = 0;
        per_err = 0; mosi_err = 0; busy_err = 0; idle_sck_err = 0;
        word = '0; sck_p = 1'b0; mosi_p = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                if (in_frame) begin
                    check("abort_expected", 32'(cur.abort), 32'd1);
                    in_frame = 0;
                end
                wait_done = 0;
                high_cnt = 0;
                sck_p = 1'b0;
                mosi_p = 1'b0;
            end else begin
                if (!in_frame && !cs_m) begin
                    if (sb.size() == 0) begin
                        check("unexpected_frame", 32'd1, 32'd0);
                        cur = '{word: 32'h0, nbits: 0, cslow: 0, gap: 0, period: 0, abort: 1'b0};
                    end else begin
                        cur = sb.pop_front();
                    end
                    if (cur.gap != 0) check("cs_high_gap", high_cnt, cur.gap);
                    if (wait_done) begin
                        check("done_before_next_frame", 32'd0, 32'd1);
                        wait_done = 0;
                    end
                    in_frame = 1;
                    low_cnt = 0; rises = 0; word = '0;
                    per_err = 0; mosi_err = 0; busy_err = 0;
                end else if (in_frame && !cs_m) begin
                    if (mosi_m !== mosi_p && !(sck_p && !sck_m)) mosi_err++;
                end

                if (in_frame && !cs_m) begin
                    low_cnt++;
                    if (!busy_m) busy_err++;
                    if (done_m) check("done_in_frame", 32'(done_m), 32'd0);
                    if (sck_m && !sck_p) begin
                        word = {word[30:0], mosi_m};
                        if (rises > 0 && (cyc - last_rise) != cur.period) per_err++;
                        last_rise = cyc;
                        rises++;
                    end
                end else if (in_frame && cs_m) begin
                    in_frame = 0;
                    check("rise_count", rises, cur.nbits);
                    check("frame_bits", word, cur.word);
                    check("cs_low_len", low_cnt, cur.cslow);
                    check("sck_period_errs", per_err, 0);
                    check("mosi_change_errs", mosi_err, 0);
                    check("busy_low_in_frame", busy_err, 0);
                    if (sck_m) idle_sck_err++;
                    wait_done = 1;
                    gap_cnt = 0;
                    high_cnt = 1;
                end else begin
                    high_cnt++;
                    if (sck_m) idle_sck_err++;
                    if (wait_done) begin
                        gap_cnt++;
                        if (done_m) begin
                            check("done_delay", gap_cnt, 8);
                            check("busy_at_done", 32'(busy_m), 32'd0);
                            wait_done = 0;
                        end else if (!busy_m) begin
                            check("busy_in_gap", 32'(busy_m), 32'd1);
                        end
                    end else if (done_m) begin
                        check("done_unexpected", 32'(done_m), 32'd0);
                    end
                end
                sck_p = sck_m;
                mosi_p = mosi_m;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_exp(input logic [31:0] w, input int nbits, input int gap, input bit abort);
        int div;
        exp_t e;
        div = sel ? 1 : 5;
        e.word = w; e.nbits = nbits; e.cslow = 4 + 2 * div * nbits + 4;
        e.gap = gap; e.period = 2 * div; e.abort = abort;
        sb.push_back(e);
    endtask

    task automatic send(input logic [7:0] op, input logic [23:0] ad, input logic [1:0] ln,
                        input logic [31:0] w, input bit abort);
        push_exp(w, 8 * (1 + int'(ln)), 0, abort);
        @(posedge clk); #1;
        opcode = op; addr = ad; alen = ln;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        check("accept_busy", 32'(busy_m), 32'd1);
        check("accept_cs", 32'(cs_m), 32'd0);
        check("accept_mosi", 32'(mosi_m), 32'(op[7]));
    endtask

    task automatic wait_quiet();
        int t;
        t = 0;
        while ((in_frame || wait_done || sb.size() != 0) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 3000) check("wait_timeout", 32'd1, 32'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1. reset state and quiet idle
        #12;
        check("rst_cs", 32'(cs_m), 32'd1);
        check("rst_sck", 32'(sck_m), 32'd0);
        check("rst_mosi", 32'(mosi_m), 32'd0);
        check("rst_busy", 32'(busy_m), 32'd0);
        check("rst_done", 32'(done_m), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("idle_cs", 32'(cs_m), 32'd1);
        check("idle_busy", 32'(busy_m), 32'd0);
        check("idle_sck", 32'(sck_m), 32'd0);

        // 2. Program Execute with 24-bit row address
        send(8'h10, 24'h000123, 2'd3, 32'h10000123, 1'b0);
        wait_quiet();

        // 3. opcode only
        send(8'h06, 24'hABCDEF, 2'd0, 32'h00000006, 1'b0);
        wait_quiet();

        // 4. fastest SCK, one address byte
        sel = 1'b1;
        send(8'hA5, 24'hFFFF3C, 2'd1, 32'h0000A53C, 1'b0);
        wait_quiet();
        sel = 1'b0;

        // 5a. START pulsed mid-shift with new inputs must not disturb or queue
        send(8'h9F, 24'h00ABCD, 2'd2, 32'h009FABCD, 1'b0);
        repeat (100) @(posedge clk);
        #1;
        opcode = 8'hFF; addr = 24'hFFFFFF; alen = 2'd3; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        wait_quiet();
        repeat (200) @(posedge clk);
        #1;
        check("no_second_frame_cs", 32'(cs_m), 32'd1);
        check("no_second_frame_busy", 32'(busy_m), 32'd0);

        // 5b. START held high: back-to-back frames with a 9-cycle CS-high gap
        push_exp(32'h00000005, 8, 0, 1'b0);
        push_exp(32'h00000005, 8, 9, 1'b0);
        push_exp(32'h00000005, 8, 9, 1'b0);
        @(posedge clk); #1;
        opcode = 8'h05; addr = 24'h0; alen = 2'd0; start0 = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        start0 = 1'b0;
        wait_quiet();

        // 6. asynchronous reset during bit 12 of a 24-bit frame
        send(8'h3B, 24'h123456, 2'd2, 32'h003B3456, 1'b1);
        repeat (129) @(posedge clk);
        #2;
        check("pre_reset_sck_high", 32'(sck_m), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_cs", 32'(cs_m), 32'd1);
        check("async_rst_sck", 32'(sck_m), 32'd0);
        check("async_rst_busy", 32'(busy_m), 32'd0);
        check("async_rst_mosi", 32'(mosi_m), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        send(8'h3B, 24'h123456, 2'd2, 32'h003B3456, 1'b0);
        wait_quiet();

        check("sck_toggle_while_cs_high", idle_sck_err, 0);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
